// File: rtl/y86_pkg.sv
// Shared Y86 decode definitions: instruction codes, special register
// indices and the decoded register-ID bundle.
package y86_pkg;

    localparam int REG_IDX_W = 4;

    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVQ = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    localparam logic [REG_IDX_W-1:0] RNONE = 4'hF;
    localparam logic [REG_IDX_W-1:0] RSP   = 4'h4;

    typedef struct packed {
        logic [REG_IDX_W-1:0] srcA;
        logic [REG_IDX_W-1:0] srcB;
        logic [REG_IDX_W-1:0] dstE;
        logic [REG_IDX_W-1:0] dstM;
    } dec_ids_t;

endpackage

// File: rtl/y86_regfile.sv
// Y86 register file: two forwarding read ports, two write ports (E, M).
// The all-ones index is RNONE: reads return 0, writes are dropped.
module y86_regfile #(
    parameter int DATA_W   = 64,
    parameter int IDX_W    = 4,
    parameter int REG_INIT = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [IDX_W-1:0]  src_a_i,
    input  logic [IDX_W-1:0]  src_b_i,
    output logic [DATA_W-1:0] val_a_o,
    output logic [DATA_W-1:0] val_b_o,
    input  logic              e_en_i,
    input  logic [IDX_W-1:0]  dst_e_i,
    input  logic [DATA_W-1:0] val_e_i,
    input  logic              m_en_i,
    input  logic [IDX_W-1:0]  dst_m_i,
    input  logic [DATA_W-1:0] val_m_i
);

    localparam int NREGS = (2 ** IDX_W) - 1;
    localparam logic [IDX_W-1:0] RNONE_L = {IDX_W{1'b1}};

    logic [DATA_W-1:0] regs_q [0:NREGS-1];

    logic e_wr;
    logic m_wr;

    assign e_wr = e_en_i && (dst_e_i != RNONE_L);
    assign m_wr = m_en_i && (dst_m_i != RNONE_L);

    // M is written last so it wins when both ports hit the same register.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= (REG_INIT != 0) ? DATA_W'(i + 1) : '0;
            end
        end else begin
            if (e_wr) begin
                regs_q[dst_e_i] <= val_e_i;
            end
            if (m_wr) begin
                regs_q[dst_m_i] <= val_m_i;
            end
        end
    end

    always_comb begin
        if (src_a_i == RNONE_L) begin
            val_a_o = '0;
        end else if (m_wr && (dst_m_i == src_a_i)) begin
            val_a_o = val_m_i;
        end else if (e_wr && (dst_e_i == src_a_i)) begin
            val_a_o = val_e_i;
        end else begin
            val_a_o = regs_q[src_a_i];
        end
    end

    always_comb begin
        if (src_b_i == RNONE_L) begin
            val_b_o = '0;
        end else if (m_wr && (dst_m_i == src_b_i)) begin
            val_b_o = val_m_i;
        end else if (e_wr && (dst_e_i == src_b_i)) begin
            val_b_o = val_e_i;
        end else begin
            val_b_o = regs_q[src_b_i];
        end
    end

endmodule

// File: rtl/y86_decode_rf.sv
// Y86 decode stage: register-ID decode, register file read with
// writeback forwarding, and a stallable/bubbleable D/E output stage.
module y86_decode_rf
    import y86_pkg::*;
#(
    parameter int DATA_W   = 64,
    parameter int IDX_W    = 4,
    parameter int RSP_IDX  = 4,
    parameter int REG_INIT = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [3:0]        icode,
    input  logic [IDX_W-1:0]  rA,
    input  logic [IDX_W-1:0]  rB,
    input  logic              stall,
    input  logic              bubble,
    input  logic              wb_e_en,
    input  logic [IDX_W-1:0]  wb_dst_e,
    input  logic [DATA_W-1:0] wb_val_e,
    input  logic              wb_m_en,
    input  logic [IDX_W-1:0]  wb_dst_m,
    input  logic [DATA_W-1:0] wb_val_m,
    output logic              d_valid,
    output logic [3:0]        d_icode,
    output logic [DATA_W-1:0] d_valA,
    output logic [DATA_W-1:0] d_valB,
    output logic [IDX_W-1:0]  d_srcA,
    output logic [IDX_W-1:0]  d_srcB,
    output logic [IDX_W-1:0]  d_dstE,
    output logic [IDX_W-1:0]  d_dstM
);

    localparam logic [IDX_W-1:0] RNONE_L = {IDX_W{1'b1}};
    localparam logic [IDX_W-1:0] RSP_L   = IDX_W'(RSP_IDX);

    dec_ids_t          ids;
    dec_ids_t          ids_d, ids_q;
    logic [DATA_W-1:0] rd_a, rd_b;
    logic              valid_d, valid_q;
    logic [3:0]        icode_d, icode_q;
    logic [DATA_W-1:0] val_a_d, val_a_q;
    logic [DATA_W-1:0] val_b_d, val_b_q;

    always_comb begin
        ids = '{RNONE_L, RNONE_L, RNONE_L, RNONE_L};
        case (icode)
            IRRMOVQ: begin ids.srcA = rA; ids.dstE = rB; end
            IIRMOVQ: begin ids.dstE = rB; end
            IRMMOVQ: begin ids.srcA = rA; ids.srcB = rB; end
            IMRMOVQ: begin ids.srcB = rB; ids.dstM = rA; end
            IOPQ: begin
                ids.srcA = rA; ids.srcB = rB; ids.dstE = rB;
            end
            ICALL: begin ids.srcB = RSP_L; ids.dstE = RSP_L; end
            IRET: begin
                ids.srcA = RSP_L; ids.srcB = RSP_L; ids.dstE = RSP_L;
            end
            IPUSHQ: begin
                ids.srcA = rA; ids.srcB = RSP_L; ids.dstE = RSP_L;
            end
            IPOPQ: begin
                ids.srcA = RSP_L; ids.srcB = RSP_L;
                ids.dstE = RSP_L; ids.dstM = rA;
            end
            default: ;
        endcase
    end

    y86_regfile #(
        .DATA_W   (DATA_W),
        .IDX_W    (IDX_W),
        .REG_INIT (REG_INIT)
    ) u_rf (
        .clk     (clk),
        .rst     (rst),
        .src_a_i (ids.srcA),
        .src_b_i (ids.srcB),
        .val_a_o (rd_a),
        .val_b_o (rd_b),
        .e_en_i  (wb_e_en),
        .dst_e_i (wb_dst_e),
        .val_e_i (wb_val_e),
        .m_en_i  (wb_m_en),
        .dst_m_i (wb_dst_m),
        .val_m_i (wb_val_m)
    );

    // An empty slot (in_valid low) is loaded exactly like a bubble.
    always_comb begin
        valid_d = valid_q;
        icode_d = icode_q;
        val_a_d = val_a_q;
        val_b_d = val_b_q;
        ids_d   = ids_q;
        if (bubble || (!stall && !in_valid)) begin
            valid_d = 1'b0;
            icode_d = INOP;
            val_a_d = '0;
            val_b_d = '0;
            ids_d   = '{RNONE_L, RNONE_L, RNONE_L, RNONE_L};
        end else if (!stall) begin
            valid_d = 1'b1;
            icode_d = icode;
            val_a_d = rd_a;
            val_b_d = rd_b;
            ids_d   = ids;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            icode_q <= INOP;
            val_a_q <= '0;
            val_b_q <= '0;
            ids_q   <= '{RNONE_L, RNONE_L, RNONE_L, RNONE_L};
        end else begin
            valid_q <= valid_d;
            icode_q <= icode_d;
            val_a_q <= val_a_d;
            val_b_q <= val_b_d;
            ids_q   <= ids_d;
        end
    end

    assign d_valid = valid_q;
    assign d_icode = icode_q;
    assign d_valA  = val_a_q;
    assign d_valB  = val_b_q;
    assign d_srcA  = ids_q.srcA;
    assign d_srcB  = ids_q.srcB;
    assign d_dstE  = ids_q.dstE;
    assign d_dstM  = ids_q.dstM;

endmodule

// File: tb/tb_y86_decode_rf.sv
// Scoreboard bench for y86_decode_rf (REG_INIT=1): directed scenarios
// with hand-computed results plus a randomized run against a model.
module tb_y86_decode_rf;

    typedef struct packed {
        logic        v;
        logic [3:0]  ic;
        logic [63:0] a;
        logic [63:0] b;
        logic [3:0]  sa;
        logic [3:0]  sb;
        logic [3:0]  de;
        logic [3:0]  dm;
    } out_t;

    logic        clk = 1'b0;
    logic        rst, in_valid, stall, bubble;
    logic [3:0]  icode, rA, rB;
    logic        wb_e_en, wb_m_en;
    logic [3:0]  wb_dst_e, wb_dst_m;
    logic [63:0] wb_val_e, wb_val_m;
    logic        d_valid;
    logic [3:0]  d_icode, d_srcA, d_srcB, d_dstE, d_dstM;
    logic [63:0] d_valA, d_valB;

    out_t        obs;
    out_t        sbq[$];
    out_t        last;
    out_t        e;
    logic [63:0] mreg [0:14];
    int          nvec = 0;
    int          nbad = 0;

    always #5 clk = ~clk;

    y86_decode_rf #(
        .DATA_W(64), .IDX_W(4), .RSP_IDX(4), .REG_INIT(1)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .icode(icode),
        .rA(rA), .rB(rB), .stall(stall), .bubble(bubble),
        .wb_e_en(wb_e_en), .wb_dst_e(wb_dst_e), .wb_val_e(wb_val_e),
        .wb_m_en(wb_m_en), .wb_dst_m(wb_dst_m), .wb_val_m(wb_val_m),
        .d_valid(d_valid), .d_icode(d_icode),
        .d_valA(d_valA), .d_valB(d_valB),
        .d_srcA(d_srcA), .d_srcB(d_srcB),
        .d_dstE(d_dstE), .d_dstM(d_dstM)
    );

    assign obs = {d_valid, d_icode, d_valA, d_valB,
                  d_srcA, d_srcB, d_dstE, d_dstM};

    function automatic out_t mk(logic v, logic [3:0] ic,
                                logic [63:0] a, logic [63:0] b,
                                logic [3:0] sa, logic [3:0] sb,
                                logic [3:0] de, logic [3:0] dm);
        return {v, ic, a, b, sa, sb, de, dm};
    endfunction

    function automatic out_t nop_o();
        return mk(1'b0, 4'h1, 64'h0, 64'h0, 4'hF, 4'hF, 4'hF, 4'hF);
    endfunction

    function automatic logic [63:0] mread(logic [3:0] s);
        if (s == 4'hF) return 64'h0;
        if (wb_m_en && wb_dst_m == s) return wb_val_m;
        if (wb_e_en && wb_dst_e == s) return wb_val_e;
        return mreg[s];
    endfunction

    function automatic out_t predict();
        logic [3:0] sa, sb, de, dm;
        if (rst || bubble) return nop_o();
        if (stall) return last;
        if (!in_valid) return nop_o();
        sa = 4'hF; sb = 4'hF; de = 4'hF; dm = 4'hF;
        if (icode inside {4'h2, 4'h4, 4'h6, 4'hA}) sa = rA;
        if (icode inside {4'h9, 4'hB}) sa = 4'h4;
        if (icode inside {4'h4, 4'h5, 4'h6}) sb = rB;
        if (icode inside {4'h8, 4'h9, 4'hA, 4'hB}) sb = 4'h4;
        if (icode inside {4'h2, 4'h3, 4'h6}) de = rB;
        if (icode inside {4'h8, 4'h9, 4'hA, 4'hB}) de = 4'h4;
        if (icode inside {4'h5, 4'hB}) dm = rA;
        return mk(1'b1, icode, mread(sa), mread(sb), sa, sb, de, dm);
    endfunction

    task automatic push(input out_t x);
        sbq.push_back(x);
        last = x;
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 15; i++) mreg[i] = 64'(i + 1);
        end else begin
            if (wb_e_en && wb_dst_e != 4'hF) mreg[wb_dst_e] = wb_val_e;
            if (wb_m_en && wb_dst_m != 4'hF) mreg[wb_dst_m] = wb_val_m;
        end
        #1;
    endtask

    task automatic idle();
        rst = 0; in_valid = 0; stall = 0; bubble = 0;
        icode = 4'h1; rA = 4'hF; rB = 4'hF;
        wb_e_en = 0; wb_dst_e = 4'hF; wb_val_e = 0;
        wb_m_en = 0; wb_dst_m = 4'hF; wb_val_m = 0;
    endtask

    task automatic test_reset();
        idle();
        rst = 1; wb_e_en = 1; wb_dst_e = 4'h2; wb_val_e = 64'h55;
        push(nop_o());
        tick();
        e = sbq.pop_front(); nvec++;
        if (obs !== e) begin
            nbad++; $display("FAIL reset got %h want %h", obs, e);
        end
        @(negedge clk); idle();
        in_valid = 1; icode = 4'h2; rA = 4'h2; rB = 4'h0;
        push(mk(1, 4'h2, 64'h3, 64'h0, 4'h2, 4'hF, 4'h0, 4'hF));
        tick();
        e = sbq.pop_front(); nvec++;
        if (obs !== e) begin
            nbad++; $display("FAIL reset_wb_drop got %h want %h", obs, e);
        end
    endtask

    task automatic test_opq();
        @(negedge clk); idle();
        in_valid = 1; icode = 4'h6; rA = 4'h2; rB = 4'h3;
        push(mk(1, 4'h6, 64'h3, 64'h4, 4'h2, 4'h3, 4'h3, 4'hF));
        tick();
        e = sbq.pop_front(); nvec++;
        if (obs !== e) begin
            nbad++; $display("FAIL opq got %h want %h", obs, e);
        end
    endtask

    task automatic test_popq();
        @(negedge clk); idle();
        wb_m_en = 1; wb_dst_m = 4'h4; wb_val_m = 64'h100;
        push(nop_o());
        tick();
        e = sbq.pop_front(); nvec++;
        if (obs !== e) begin
            nbad++; $display("FAIL empty_slot got %h want %h", obs, e);
        end
        @(negedge clk); idle();
        in_valid = 1; icode = 4'hB; rA = 4'h1; rB = 4'hF;
        push(mk(1, 4'hB, 64'h100, 64'h100, 4'h4, 4'h4, 4'h4, 4'h1));
        tick();
        e = sbq.pop_front(); nvec++;
        if (obs !== e) begin
            nbad++; $display("FAIL popq got %h want %h", obs, e);
        end
    endtask

    task automatic test_forward();
        @(negedge clk); idle();
        in_valid = 1; icode = 4'h4; rA = 4'h5; rB = 4'h6;
        wb_e_en = 1; wb_dst_e = 4'h5; wb_val_e = 64'hAA;
        wb_m_en = 1; wb_dst_m = 4'h5; wb_val_m = 64'hBB;
        push(mk(1, 4'h4, 64'hBB, 64'h7, 4'h5, 4'h6, 4'hF, 4'hF));
        tick();
        e = sbq.pop_front(); nvec++;
        if (obs !== e) begin
            nbad++; $display("FAIL fwd_m_over_e got %h want %h", obs, e);
        end
        @(negedge clk); idle();
        in_valid = 1; icode = 4'h2; rA = 4'h5; rB = 4'h0;
        push(mk(1, 4'h2, 64'hBB, 64'h0, 4'h5, 4'hF, 4'h0, 4'hF));
        tick();
        e = sbq.pop_front(); nvec++;
        if (obs !== e) begin
            nbad++; $display("FAIL fwd_stored got %h want %h", obs, e);
        end
    endtask

    task automatic test_stall();
        @(negedge clk); idle();
        in_valid = 1; icode = 4'h6; rA = 4'h1; rB = 4'h0;
        push(mk(1, 4'h6, 64'h2, 64'h1, 4'h1, 4'h0, 4'h0, 4'hF));
        tick();
        e = sbq.pop_front(); nvec++;
        if (obs !== e) begin
            nbad++; $display("FAIL stall_load got %h want %h", obs, e);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); idle();
            stall = 1; in_valid = 1; icode = 4'(i + 8);
            rA = 4'(i); rB = 4'(i + 3);
            if (i == 0) begin
                wb_e_en = 1; wb_dst_e = 4'h1; wb_val_e = 64'h77;
            end
            push(mk(1, 4'h6, 64'h2, 64'h1, 4'h1, 4'h0, 4'h0, 4'hF));
            tick();
            e = sbq.pop_front(); nvec++;
            if (obs !== e) begin
                nbad++; $display("FAIL stall_hold%0d got %h want %h", i, obs, e);
            end
        end
        @(negedge clk); idle();
        in_valid = 1; icode = 4'h2; rA = 4'h1; rB = 4'h2;
        push(mk(1, 4'h2, 64'h77, 64'h0, 4'h1, 4'hF, 4'h2, 4'hF));
        tick();
        e = sbq.pop_front(); nvec++;
        if (obs !== e) begin
            nbad++; $display("FAIL stall_release got %h want %h", obs, e);
        end
    endtask

    task automatic test_stall_bubble();
        @(negedge clk); idle();
        stall = 1; bubble = 1; in_valid = 1;
        icode = 4'h6; rA = 4'h2; rB = 4'h3;
        push(nop_o());
        tick();
        e = sbq.pop_front(); nvec++;
        if (obs !== e) begin
            nbad++; $display("FAIL stall_bubble got %h want %h", obs, e);
        end
    endtask

    task automatic test_reset_mid_stall();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); idle();
            in_valid = 1; icode = 4'hA; rA = 4'h3; rB = 4'hF;
            stall = (i == 1 || i == 2);
            rst = (i == 2);
            push(predict());
            tick();
            e = sbq.pop_front(); nvec++;
            if (obs !== e) begin
                nbad++; $display("FAIL rst_stall%0d got %h want %h", i, obs, e);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 60; i++) begin
            @(negedge clk); idle();
            rst      = ($urandom_range(0, 29) == 0);
            in_valid = ($urandom_range(0, 3) != 0);
            stall    = ($urandom_range(0, 3) == 0);
            bubble   = ($urandom_range(0, 5) == 0);
            icode    = 4'($urandom_range(0, 15));
            rA       = 4'($urandom_range(0, 15));
            rB       = 4'($urandom_range(0, 15));
            wb_e_en  = $urandom_range(0, 1) == 1;
            wb_dst_e = 4'($urandom_range(0, 15));
            wb_val_e = {$urandom, $urandom};
            wb_m_en  = $urandom_range(0, 1) == 1;
            wb_dst_m = 4'($urandom_range(0, 15));
            wb_val_m = {$urandom, $urandom};
            push(predict());
            tick();
            e = sbq.pop_front(); nvec++;
            if (obs !== e) begin
                nbad++; $display("FAIL random%0d got %h want %h", i, obs, e);
            end
        end
    endtask

    initial begin
        idle();
        rst = 1;
        last = nop_o();
        test_reset();
        test_opq();
        test_popq();
        test_forward();
        test_stall();
        test_stall_bubble();
        test_reset_mid_stall();
        test_random();
        nvec++;
        if (sbq.size() != 0) begin
            nbad++; $display("FAIL sb_drain got %0d want 0", sbq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

endmodule
